rf_wb_arbiter: RTL and testbench

Writeback arbiter and scoreboard for the single-write-port register file. It shares the file's one write port between the ALU writeback source and the load/store unit, and registers the winning write onto the port. It also tracks which architectural registers have an outstanding write, so issue logic can stall RAW and WAW hazards. It sits between the EXU/LSU writeback paths and the register file.

---
 rtl/rf_wb_arbiter.sv | 111 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter and busy-register scoreboard for the single-write-port register file.
// Define RF_WB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int REG_NUM_BIT = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_NUM_BIT-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]  alu_data,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [REG_NUM_BIT-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]  lsu_data,
    input  logic                   issue_valid,
    input  logic [REG_NUM_BIT-1:0] issue_rd,
    output logic                   issue_ready,
    input  logic [REG_NUM_BIT-1:0] rs1_addr,
    input  logic [REG_NUM_BIT-1:0] rs2_addr,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   rf_wen,
    output logic [REG_NUM_BIT-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]  rf_wdata
);

    // Handshake: a transfer fires when valid && ready on the same posedge. ready is
    // derived only from the valid inputs and the priority state, never from the
    // other source's ready; a source that loses holds valid and payload stable.

    logic                   prefer_alu;
    logic                   grant;
    logic [REG_NUM_BIT-1:0] win_rd;
    logic [DATA_WIDTH-1:0]  win_data;
    logic [REG_NUM-1:0]     busy;
    logic [REG_NUM-1:0]     busy_next;
    logic                   issue_fire;

`ifdef RF_WB_RR_EN
    // 1 = ALU preferred on contention; flips only when both sources compete.
    logic rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (alu_valid && lsu_valid) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    assign prefer_alu = rr_ptr;
`else
    assign prefer_alu = 1'b0;
`endif

    assign alu_ready = alu_valid && (!lsu_valid || prefer_alu);
    assign lsu_ready = lsu_valid && !(alu_valid && prefer_alu);
    assign grant     = alu_ready || lsu_ready;

    always_comb begin
        win_rd   = alu_rd;
        win_data = alu_data;
        if (lsu_ready) begin
            win_rd   = lsu_rd;
            win_data = lsu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= grant && (win_rd != '0);
            if (grant) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
            end
        end
    end

    assign issue_ready = !busy[issue_rd];
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
    assign rs1_busy    = busy[rs1_addr];
    assign rs2_busy    = busy[rs2_addr];

    // Set is applied after clear so a new producer wins a same-edge collision.
    always_comb begin
        busy_next = busy;
        if (rf_wen) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: writes predicted at grant are queued and a
// negedge monitor matches them against the register-file write port.
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int RB = 5;
    localparam int W  = RB + DW;

    logic          clk;
    logic          rst;
    logic          alu_valid, lsu_valid, issue_valid;
    logic          alu_ready, lsu_ready, issue_ready;
    logic [RB-1:0] alu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr;
    logic [DW-1:0] alu_data, lsu_data;
    logic          rs1_busy, rs2_busy;
    logic          rf_wen;
    logic [RB-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    logic [W-1:0] exp_q[$];
    int           total = 0;
    int           bad   = 0;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .REG_NUM(32), .REG_NUM_BIT(RB)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // driver: inputs change on negedge, combinational outputs settle by +1
    task automatic drive(input logic av, input logic [RB-1:0] ard, input logic [DW-1:0] ad,
                         input logic lv, input logic [RB-1:0] lrd, input logic [DW-1:0] ld,
                         input logic iv, input logic [RB-1:0] ird);
        @(negedge clk);
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = ad;
        lsu_valid   = lv;
        lsu_rd      = lrd;
        lsu_data    = ld;
        issue_valid = iv;
        issue_rd    = ird;
        #1;
    endtask

    task automatic expect_write(input logic [RB-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // scoreboard monitor: every write-port cycle must match the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_wen) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=%0d:%0h expected=none", rf_waddr, rf_wdata);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("wb_addr", 64'(rf_waddr), 64'(e[W-1:DW]));
                    check("wb_data", 64'(rf_wdata), 64'(e[DW-1:0]));
                end
            end else if (exp_q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL missing_write actual=rf_wen0 expected=%0h", exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0;
        rs1_addr = 0; rs2_addr = 0;
        #1;
        check("reset_wen",   64'(rf_wen), 64'(0));
        check("reset_waddr", 64'(rf_waddr), 64'(0));
        check("reset_wdata", 64'(rf_wdata), 64'(0));
        check("reset_issue_ready_x0", 64'(issue_ready), 64'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single ALU write to x5
        rs1_addr = 5;
        drive(0, 0, 0, 0, 0, 0, 1, 5);
        check("t1_issue_ready", 64'(issue_ready), 64'(1));
        check("t1_rs1_busy_pre", 64'(rs1_busy), 64'(0));
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5);
        check("t1_rs1_busy_set", 64'(rs1_busy), 64'(1));
        check("t1_waw_block", 64'(issue_ready), 64'(0));
        check("t1_alu_ready", 64'(alu_ready), 64'(1));
        check("t1_lsu_ready", 64'(lsu_ready), 64'(0));
        expect_write(5, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0, 5);
        check("t1_busy_during_write", 64'(rs1_busy), 64'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 5);
        check("t1_busy_cleared", 64'(rs1_busy), 64'(0));

        // contention between ALU x3 and LSU x4
        drive(1, 3, 32'h11, 1, 4, 32'h22, 0, 0);
        check("t2_c1_lsu_ready", 64'(lsu_ready), 64'(1));
        check("t2_c1_alu_ready", 64'(alu_ready), 64'(0));
        expect_write(4, 32'h22);
        drive(1, 3, 32'h11, 1, 4, 32'h22, 0, 0);
`ifdef RF_WB_RR_EN
        check("t2_c2_alu_ready", 64'(alu_ready), 64'(1));
        check("t2_c2_lsu_ready", 64'(lsu_ready), 64'(0));
        expect_write(3, 32'h11);
`else
        check("t2_c2_alu_ready", 64'(alu_ready), 64'(0));
        check("t2_c2_lsu_ready", 64'(lsu_ready), 64'(1));
        expect_write(4, 32'h22);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t2_idle_alu_ready", 64'(alu_ready), 64'(0));
        check("t2_idle_lsu_ready", 64'(lsu_ready), 64'(0));

        // write to x0 handshakes but never reaches the file
        rs1_addr = 0;
        drive(0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
        check("t3_lsu_ready", 64'(lsu_ready), 64'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t3_x0_busy", 64'(rs1_busy), 64'(0));

        // WAW stall, then set/clear collision on x7
        rs2_addr = 7;
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        check("t4_issue_ready", 64'(issue_ready), 64'(1));
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        check("t4_waw_stall", 64'(issue_ready), 64'(0));
        check("t4_rs2_busy", 64'(rs2_busy), 64'(1));
        drive(1, 7, 32'h77, 0, 0, 0, 0, 7);
        expect_write(7, 32'h77);
        drive(0, 0, 0, 0, 0, 0, 0, 7);
        check("t4_busy_during_write", 64'(rs2_busy), 64'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 7);
        check("t4_busy_cleared", 64'(rs2_busy), 64'(0));
        check("t4_issue_ready_free", 64'(issue_ready), 64'(1));
        drive(1, 7, 32'h78, 0, 0, 0, 0, 7);
        expect_write(7, 32'h78);
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        check("t4_collide_issue_ready", 64'(issue_ready), 64'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 7);
        check("t4_set_wins", 64'(rs2_busy), 64'(1));
        check("t4_set_wins_issue", 64'(issue_ready), 64'(0));
        drive(1, 7, 32'h79, 0, 0, 0, 0, 0);
        expect_write(7, 32'h79);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_final_clear", 64'(rs2_busy), 64'(0));

        // back-to-back ALU writes x1..x4
        for (int i = 1; i <= 4; i++) begin
            drive(1, RB'(i), 32'h100 + 32'(i), 0, 0, 0, 0, 0);
            check("t5_alu_ready", 64'(alu_ready), 64'(1));
            expect_write(RB'(i), 32'h100 + 32'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // asynchronous reset while a write to busy x5 is on the port
        rs1_addr = 5;
        drive(0, 0, 0, 0, 0, 0, 1, 5);
        drive(1, 5, 32'hCAFE, 0, 0, 0, 0, 0);
        expect_write(5, 32'hCAFE);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_pre_wen", 64'(rf_wen), 64'(1));
        check("t6_pre_busy", 64'(rs1_busy), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("t6_rst_wen", 64'(rf_wen), 64'(0));
        check("t6_rst_busy", 64'(rs1_busy), 64'(0));
        check("t6_rst_waddr", 64'(rf_waddr), 64'(0));
        check("t6_rst_wdata", 64'(rf_wdata), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
